// File: rtl/ps2_tx.sv
// ----------------------------------------------------------------------------
// ps2_tx - host-to-device PS/2 command transmitter.
//
// Pulls the clock line low for a request-to-send, then shifts out a start
// bit, eight data bits (LSB first) and odd parity on device-generated clock
// falls. It releases data for the stop bit, checks the device ACK and waits
// for the bus to go idle. The lines are open-collector, so this block only
// drives output enables and the top level builds the tristate.
//
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog. If the device stops
// clocking for TIMEOUT_CYCLES, the frame is aborted with a tx_err pulse.
// ----------------------------------------------------------------------------
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,       // asynchronous, active-low
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done,
    output logic       tx_err
);

    // One counter serves both the inhibit interval and the watchdog, so it
    // is sized for the larger of the two limits.
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_REL
    } state_e;

    state_e                  state_q, state_d;
    logic [FILTER_LEN-1:0]   filt_q, filt_d;
    logic                    fclk_q, fclk_d;
    logic [8:0]              packet_q, packet_d;
    logic [3:0]              n_q, n_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    fall;

    // Glitch filter on ps2c: the filtered level flips only when the whole window agrees.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        filt_d = {filt_q[FILTER_LEN-2:0], ps2c_in};
        fclk_d = fclk_q;
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end
    end

    assign fall = fclk_q & ~fclk_d;

    // Next-state and output decode for the transmit sequence.
    always_comb begin
        state_d  = state_q;
        packet_d = packet_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        ps2c_oe  = 1'b0;
        ps2d_oe  = 1'b0;
        tx_idle  = 1'b0;
        tx_done  = 1'b0;
        tx_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    packet_d = {~^din, din};     // odd parity in bit 8
                    cnt_d    = '0;
                    state_d  = ST_RTS;
                end
            end

            ST_RTS: begin
                ps2c_oe = 1'b1;
                ps2d_oe = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_START: begin
                ps2d_oe = 1'b1;                  // start bit is a 0
                if (fall) begin
                    n_d     = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                ps2d_oe = ~packet_q[0];
                if (fall) begin
                    packet_d = {1'b0, packet_q[8:1]};
                    n_d      = n_q + 4'd1;
                    if (n_q == 4'd8) begin
                        state_d = ST_STOP;       // parity has just been taken
                    end
                end
            end

            ST_STOP: begin
                // Data released: the stop bit reads as 1 on the bus.
                if (fall) begin
                    if (!ps2d_in) begin
                        state_d = ST_WAIT_REL;
                    end else begin
                        tx_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_REL: begin
                if (fclk_q && ps2d_in) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog: runs while the device owns the clock. It restarts on each
        // fall and yields to a normal exit when one is already under way.
        if ((state_q inside {ST_START, ST_DATA, ST_STOP, ST_WAIT_REL}) &&
            (state_d != ST_IDLE)) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                ps2c_oe = 1'b0;
                ps2d_oe = 1'b0;
                tx_err  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    // State, filter and datapath registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            filt_q   <= '1;
            fclk_q   <= 1'b1;
            packet_q <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            filt_q   <= filt_d;
            fclk_q   <= fclk_d;
            packet_q <= packet_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_tx - directed bench for ps2_tx with a behavioural PS/2 device.
// The device clocks the bus, samples data on each rising edge and optionally
// ACKs. Expected frames are hand-computed:
//   bits[0]=start, bits[8:1]=data, bits[9]=odd parity, bits[10]=stop
//   8'hED -> 11'h7DA, 8'h01 -> 11'h402, 8'h00 -> 11'h600
// ----------------------------------------------------------------------------
module tb_ps2_tx;

    localparam int unsigned INH = 5000;
    localparam int unsigned FL  = 8;
    localparam int unsigned TO  = 1000;
    localparam int          H   = 100;   // device half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe;
    logic       tx_idle, tx_done, tx_err;

    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;

    int n_assert      = 0;
    int n_fail        = 0;
    int done_cnt      = 0;
    int err_cnt       = 0;
    int both_cnt      = 0;
    int cyc           = 0;
    int last_fall_cyc = 0;

    // Open-collector bus: low if either side pulls.
    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    always #5 clk = ~clk;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_ps2 (wr_ps2),
        .din    (din),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle),
        .tx_done(tx_done),
        .tx_err (tx_err)
    );

    // Free-running cycle count for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of the status pulses.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    end

    // Hard stop so a stuck run still terminates.
    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation did not complete");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one write and play the device for up to 11 clock pulses.
    task automatic send_frame(input logic [7:0] data, input bit ack, input bit mid_wr,
                              input bit glitch, input int stop_after,
                              input logic [10:0] exp_bits, input string tag);
        logic [10:0] bits;
        int          inh;
        int          d0;
        int          e0;
        bits = '0;
        d0   = done_cnt;
        e0   = err_cnt;
        @(negedge clk);
        din    = data;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'hA5;
        check({tag, "_idle_low"}, 32'(tx_idle), 0);
        inh = 0;
        while (ps2c_oe === 1'b1 && inh < 3 * INH) begin
            inh++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, 32'(inh), INH);
        if (mid_wr) begin
            din    = 8'h55;
            wr_ps2 = 1'b1;
            @(negedge clk);
            wr_ps2 = 1'b0;
        end
        wait_cyc(H);
        bits[0] = ps2d_in;
        for (int k = 1; k <= stop_after; k++) begin
            if (k == 11 && ack) dev_d_low = 1'b1;
            dev_c_low     = 1'b1;
            last_fall_cyc = cyc;
            wait_cyc(H);
            if (k <= 10) bits[k] = ps2d_in;
            dev_c_low = 1'b0;
            if (glitch && k < 10) begin
                wait_cyc(H / 2);
                dev_c_low = 1'b1;
                wait_cyc(3);
                dev_c_low = 1'b0;
                wait_cyc(H / 2 - 3);
            end else begin
                wait_cyc(H);
            end
        end
        if (stop_after == 11) begin
            dev_d_low = 1'b0;
            wait_cyc(20);
            check({tag, "_frame_bits"}, 32'(bits), 32'(exp_bits));
            check({tag, "_done_pulses"}, 32'(done_cnt - d0), ack ? 1 : 0);
            check({tag, "_err_pulses"}, 32'(err_cnt - e0), ack ? 0 : 1);
            check({tag, "_idle_end"}, 32'(tx_idle), 1);
            check({tag, "_oe_end"}, 32'({ps2c_oe, ps2d_oe}), 0);
        end
    endtask

    initial begin
        int e0;
        int d0;
        int n;
        int elapsed;

        // Reset with a pending write request.
        rst    = 1'b0;
        wr_ps2 = 1'b1;
        din    = 8'hED;
        wait_cyc(5);
        check("rst_ps2c_oe", 32'(ps2c_oe), 0);
        check("rst_ps2d_oe", 32'(ps2d_oe), 0);
        check("rst_tx_idle", 32'(tx_idle), 1);
        check("rst_tx_done", 32'(tx_done), 0);
        check("rst_tx_err",  32'(tx_err),  0);
        wr_ps2 = 1'b0;
        rst    = 1'b1;
        wait_cyc(10);
        check("post_rst_idle", 32'(tx_idle), 1);
        check("post_rst_oe",   32'({ps2c_oe, ps2d_oe}), 0);
        check("post_rst_pulses", 32'(done_cnt + err_cnt), 0);

        // Normal frames.
        send_frame(8'hED, 1'b1, 1'b0, 1'b0, 11, 11'h7DA, "ed");
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 11, 11'h402, "x01");
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 11, 11'h600, "x00");

        // Device never ACKs.
        send_frame(8'hED, 1'b0, 1'b0, 1'b0, 11, 11'h7DA, "noack");

        // Write during a frame plus clock glitches.
        send_frame(8'hED, 1'b1, 1'b1, 1'b1, 11, 11'h7DA, "midwr_glitch");

        // Device stalls after three clock pulses.
        e0 = err_cnt;
        d0 = done_cnt;
        send_frame(8'hED, 1'b1, 1'b0, 1'b0, 3, 11'h000, "stall");
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (err_cnt == e0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        elapsed = cyc - last_fall_cyc;
        check("timeout_err_pulse", 32'(err_cnt - e0), 1);
        check("timeout_latency_window",
              32'(elapsed >= int'(TO) && elapsed <= int'(TO + FL + 4)), 1);
        wait_cyc(2);
        check("timeout_oe", 32'({ps2c_oe, ps2d_oe}), 0);
        check("timeout_idle", 32'(tx_idle), 1);
        check("timeout_no_done", 32'(done_cnt - d0), 0);
`else
        n       = 0;
        elapsed = 0;
        wait_cyc(3000);
        check("stall_no_err", 32'(err_cnt - e0), 0);
        check("stall_busy", 32'(tx_idle), 0);
        check("stall_ps2c_oe", 32'(ps2c_oe), 0);
        // Reset in the middle of the stalled frame releases both lines.
        rst = 1'b0;
        #1;
        check("midrst_oe", 32'({ps2c_oe, ps2d_oe}), 0);
        check("midrst_idle", 32'(tx_idle), 1);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(5);
        check("midrst_no_done", 32'(done_cnt - d0), 0);
`endif

        check("done_err_exclusive", 32'(both_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
